// File: rtl/ac_pkg.sv
// Shared constants and FSM encoding for the Aho-Corasick match scheduler.
package ac_pkg;
  localparam int STATE_W = 8;
  localparam int CHAR_W  = 4;

  localparam logic [STATE_W-1:0] MISS = 8'hFF;
  localparam logic [STATE_W-1:0] ROOT = 8'h00;

  typedef enum logic [2:0] {
    SCHED_IDLE,
    SCHED_GRD,
    SCHED_GCHK,
    SCHED_FRD,
    SCHED_FCHK
  } sched_state_e;
endpackage

// File: rtl/ac_sched_stats.sv
// Saturating activity counters for the match scheduler: characters emitted and failure hops.
module ac_sched_stats (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc_char,
  input  logic        inc_hop,
  output logic [31:0] stat_chars,
  output logic [31:0] stat_hops
);
  logic [31:0] chars_q, chars_d;
  logic [31:0] hops_q, hops_d;

  always_comb begin
    chars_d = chars_q;
    hops_d  = hops_q;
    if (inc_char && (chars_q != '1)) chars_d = chars_q + 32'd1;
    if (inc_hop && (hops_q != '1))   hops_d  = hops_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chars_q <= '0;
      hops_q  <= '0;
    end else begin
      chars_q <= chars_d;
      hops_q  <= hops_d;
    end
  end

  assign stat_chars = chars_q;
  assign stat_hops  = hops_q;
endmodule

// File: rtl/ac_match_sched.sv
// Aho-Corasick walk sequencer: goto lookups with failure-link retries per input character.
// Optional AC_SCHED_STATS_EN adds saturating STAT_CHARS / STAT_HOPS counters.
module ac_match_sched
  import ac_pkg::*;
#(
  parameter int unsigned MAX_HOPS = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      EN,
  input  logic                      IN_VALID,
  input  logic [CHAR_W-1:0]         IN_CHAR,
  output logic                      IN_READY,
  output logic                      G_RD,
  output logic [STATE_W+CHAR_W-1:0] G_ADDR,
  input  logic [STATE_W-1:0]        G_DATA,
  output logic                      F_RD,
  output logic [STATE_W-1:0]        F_ADDR,
  input  logic [STATE_W-1:0]        F_DATA,
  output logic                      OUT_VALID,
  output logic [STATE_W-1:0]        OUT_STATE,
  output logic [7:0]                OUT_HOPS,
  output logic                      ERR
`ifdef AC_SCHED_STATS_EN
  ,
  output logic [31:0]               STAT_CHARS,
  output logic [31:0]               STAT_HOPS
`endif
);
  localparam logic [7:0] MAX_HOPS_C = 8'(MAX_HOPS);

  sched_state_e        state_q, state_d;
  logic [STATE_W-1:0]  cur_q, cur_d;
  logic [CHAR_W-1:0]   char_q, char_d;
  logic [7:0]          hops_q, hops_d;
  logic                redo_q, redo_d;
  logic                run_q, run_d;
  logic                out_valid_q, out_valid_d;
  logic [STATE_W-1:0]  out_state_q, out_state_d;
  logic [7:0]          out_hops_q, out_hops_d;
  logic                err_q, err_d;
  logic                hop_take;

  // run_q keeps IN_READY low while reset is asserted and for the first edge after release.
  assign IN_READY = (state_q == SCHED_IDLE) && EN && run_q;
  assign G_RD     = (state_q == SCHED_GRD) && EN;
  assign F_RD     = (state_q == SCHED_FRD) && EN;
  assign G_ADDR   = G_RD ? {cur_q, char_q} : '0;
  assign F_ADDR   = F_RD ? cur_q : '0;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_d     = state_q;
    cur_d       = cur_q;
    char_d      = char_q;
    hops_d      = hops_q;
    redo_d      = redo_q;
    run_d       = 1'b1;
    out_valid_d = 1'b0;
    out_state_d = out_state_q;
    out_hops_d  = out_hops_q;
    err_d       = err_q;
    hop_take    = 1'b0;

    if (EN) begin
      unique case (state_q)
        SCHED_IDLE: begin
          if (IN_VALID && run_q) begin
            char_d  = IN_CHAR;
            hops_d  = '0;
            state_d = SCHED_GRD;
          end
        end
        SCHED_GRD: state_d = SCHED_GCHK;
        SCHED_GCHK: begin
          // Data read before a freeze is no longer on the bus; re-issue the read.
          if (redo_q) begin
            redo_d  = 1'b0;
            state_d = SCHED_GRD;
          end else if (G_DATA != MISS) begin
            cur_d       = G_DATA;
            out_valid_d = 1'b1;
          end else if (cur_q == ROOT) begin
            out_valid_d = 1'b1;
          end else if (hops_q == MAX_HOPS_C) begin
            err_d       = 1'b1;
            cur_d       = ROOT;
            out_valid_d = 1'b1;
          end else begin
            hops_d   = hops_q + 8'd1;
            hop_take = 1'b1;
            state_d  = SCHED_FRD;
          end
        end
        SCHED_FRD: state_d = SCHED_FCHK;
        SCHED_FCHK: begin
          if (redo_q) begin
            redo_d  = 1'b0;
            state_d = SCHED_FRD;
          end else begin
            cur_d   = F_DATA;
            state_d = SCHED_GRD;
          end
        end
        default: state_d = SCHED_IDLE;
      endcase
    end else if ((state_q == SCHED_GCHK) || (state_q == SCHED_FCHK)) begin
      redo_d = 1'b1;
    end

    if (out_valid_d) begin
      out_state_d = cur_d;
      out_hops_d  = hops_q;
      state_d     = SCHED_IDLE;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= SCHED_IDLE;
      cur_q       <= ROOT;
      char_q      <= '0;
      hops_q      <= '0;
      redo_q      <= 1'b0;
      run_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_state_q <= ROOT;
      out_hops_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      cur_q       <= cur_d;
      char_q      <= char_d;
      hops_q      <= hops_d;
      redo_q      <= redo_d;
      run_q       <= run_d;
      out_valid_q <= out_valid_d;
      out_state_q <= out_state_d;
      out_hops_q  <= out_hops_d;
      err_q       <= err_d;
    end
  end

  assign OUT_VALID = out_valid_q;
  assign OUT_STATE = out_state_q;
  assign OUT_HOPS  = out_hops_q;
  assign ERR       = err_q;

`ifdef AC_SCHED_STATS_EN
  ac_sched_stats u_stats (
    .clk       (CLK),
    .rst_n     (RST),
    .inc_char  (out_valid_d),
    .inc_hop   (hop_take),
    .stat_chars(STAT_CHARS),
    .stat_hops (STAT_HOPS)
  );
`endif
endmodule
